// File: rtl/div_if.sv
// Execute-stage <-> divider request/response bundle.
// The execute stage drives the master side and the divider drives the slave side.
interface div_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle.
// Signed operands are divided as magnitudes and the signs are restored at the end.
module div #(
  parameter int unsigned DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0]    work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_dvd_q, neg_dvd_d;
  logic                neg_dvs_q, neg_dvs_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                ready_q, ready_d;

  logic                op1_neg, op2_neg;
  logic [DATA_W-1:0]   op1_mag, op2_mag;
  logic [DATA_W:0]     rem_trial;
  logic                rem_ge;
  logic [DATA_W-1:0]   rem_diff;
  logic [DATA_W-1:0]   quo_cur, rem_cur;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  logic                cnt_done;
  logic                accept;

  // Operand magnitudes for the latch; only meaningful in signed mode.
  assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? (DATA_W'(0) - bus.opdata1_i) : bus.opdata1_i;
  assign op2_mag = op2_neg ? (DATA_W'(0) - bus.opdata2_i) : bus.opdata2_i;

  // One restoring step: the shifted partial remainder is DATA_W+1 bits wide.
  assign rem_trial = work_q[RES_W-1:DATA_W-1];
  assign rem_ge    = rem_trial >= {1'b0, divisor_q};
  assign rem_diff  = rem_trial[DATA_W-1:0] - divisor_q;

  assign quo_cur  = work_q[DATA_W-1:0];
  assign rem_cur  = work_q[RES_W-1:DATA_W];
  assign quo_fix  = (neg_dvd_q ^ neg_dvs_q) ? (DATA_W'(0) - quo_cur) : quo_cur;
  assign rem_fix  = neg_dvd_q ? (DATA_W'(0) - rem_cur) : rem_cur;
  assign cnt_done = (cnt_q == CNT_W'(DATA_W));
  assign accept   = bus.start_i & ~bus.annul_i;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FREE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FREE: begin
        if (accept) state_d = (bus.opdata2_i == '0) ? BYZERO : ON;
      end
      BYZERO: state_d = END;
      ON: begin
        if (bus.annul_i)   state_d = FREE;
        else if (cnt_done) state_d = END;
      end
      END: begin
        if (!bus.start_i) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      FREE: begin
        cnt_d    = '0;
        result_d = '0;
        ready_d  = 1'b0;
        if (accept && (bus.opdata2_i != '0)) begin
          work_d    = {DATA_W'(0), op1_mag};
          divisor_d = op2_mag;
          neg_dvd_d = op1_neg;
          neg_dvs_d = op2_neg;
        end
      end
      BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
      end
      ON: begin
        if (bus.annul_i) begin
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (!cnt_done) begin
          work_d = {(rem_ge ? rem_diff : rem_trial[DATA_W-1:0]),
                    work_q[DATA_W-2:0], rem_ge};
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end
      END: begin
        // Result is held for as long as the execute stage keeps start high.
        if (!bus.start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        cnt_d    = '0;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
